// File: rtl/ram_param_sync.sv
// ============================================================================
// Module  : ram_param_sync
// Purpose : WIDTH x DEPTH single-port flop RAM with req/ready handshake,
//           registered read port, range check and sequenced wipe engine.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module ram_param_sync #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              wipe,
  output logic              ready,
  output logic              busy,
  output logic              rvalid,
  output logic [WIDTH-1:0]  data_out,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WIPE = 1'b1
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] cnt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_word;
  logic              accept;
  logic              in_range;

  assign ready    = (state == IDLE) && !wipe;
  assign busy     = (state == WIPE);
  assign accept   = req && ready;
  assign in_range = ({1'b0, addr} < DEPTH_EXT);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (wipe) next_state = WIPE;
      WIPE:    if (cnt == LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Counter parks on the last word instead of wrapping.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (state == IDLE && wipe) begin
      cnt <= '0;
    end else if (state == WIPE && cnt != LAST) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (state == WIPE && cnt == ADDR_W'(k)) begin
          mem[k] <= '0;
        end else if (accept && rw && addr == ADDR_W'(k)) begin
          mem[k] <= data_in;
        end
      end
    end
  end

  // Addresses with no matching word fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (addr == ADDR_W'(k)) rd_word = mem[k];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rvalid   <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end else begin
      rvalid <= accept && !rw;
      err    <= accept && !in_range;
      if (accept && !rw) begin
        data_out <= rd_word;
      end
    end
  end

endmodule

`default_nettype wire
